// File: rtl/kamacore_decode_issue_if.sv
// Handshake bundle between fetch, the decode/issue stage, execute and writeback.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface kamacore_decode_issue_if #(
    parameter int unsigned CPU_WIDTH = 32
);

    // Fetch -> decode
    logic                 in_valid;
    logic                 in_ready;
    logic [CPU_WIDTH-1:0] in_instr;

    // Decode -> execute
    logic                 out_valid;
    logic                 out_ready;
    logic [CPU_WIDTH-1:0] out_op_a;
    logic [CPU_WIDTH-1:0] out_op_b;
    logic [3:0]           out_alu_op;
    logic [4:0]           out_rd;
    logic                 out_illegal;

    // Writeback -> register file
    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic [CPU_WIDTH-1:0] wb_data;

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_op_a,
        output out_op_b,
        output out_alu_op,
        output out_rd,
        output out_illegal,
        input  wb_valid,
        input  wb_rd,
        input  wb_data
    );

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_op_a,
        input  out_op_b,
        input  out_alu_op,
        input  out_rd,
        input  out_illegal,
        output wb_valid,
        output wb_rd,
        output wb_data
    );

endinterface

// File: rtl/kamacore_decode_issue.sv
// Decode/issue stage for RV32I OP and OP-IMM: register read with writeback bypass,
// scoreboard hazard stall, and a single registered issue slot towards the ALU.
module kamacore_decode_issue #(
    parameter int unsigned CPU_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    kamacore_decode_issue_if.slave  bus
);

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] Funct7Std = 7'b0000000;
    localparam logic [6:0] Funct7Alt = 7'b0100000;

    // Architectural state
    logic [CPU_WIDTH-1:0] rf_q [NUM_REGS];
    logic [CPU_WIDTH-1:0] rf_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    // Issue slot
    logic                 out_valid_q, out_valid_d;
    logic [CPU_WIDTH-1:0] op_a_q, op_a_d;
    logic [CPU_WIDTH-1:0] op_b_q, op_b_d;
    alu_op_e              alu_op_q, alu_op_d;
    logic [4:0]           rd_q, rd_d;
    logic                 illegal_q, illegal_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] dec_rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = bus.in_instr[6:0];
    assign dec_rd = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];

    logic    dec_legal;
    logic    dec_is_op;
    logic    dec_shift;
    alu_op_e dec_alu;

    always_comb begin
        dec_legal = 1'b0;
        dec_is_op = 1'b0;
        dec_shift = 1'b0;
        dec_alu   = AluAdd;
        case (opcode)
            OpcOpImm: begin
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = AluAdd;  end
                    3'b010: begin dec_legal = 1'b1; dec_alu = AluSlt;  end
                    3'b011: begin dec_legal = 1'b1; dec_alu = AluSltu; end
                    3'b100: begin dec_legal = 1'b1; dec_alu = AluXor;  end
                    3'b110: begin dec_legal = 1'b1; dec_alu = AluOr;   end
                    3'b111: begin dec_legal = 1'b1; dec_alu = AluAnd;  end
                    3'b001: begin
                        dec_shift = 1'b1;
                        if (funct7 == Funct7Std) begin
                            dec_legal = 1'b1;
                            dec_alu   = AluSll;
                        end
                    end
                    3'b101: begin
                        dec_shift = 1'b1;
                        if (funct7 == Funct7Std) begin
                            dec_legal = 1'b1;
                            dec_alu   = AluSrl;
                        end else if (funct7 == Funct7Alt) begin
                            dec_legal = 1'b1;
                            dec_alu   = AluSra;
                        end
                    end
                    default: ;
                endcase
            end
            OpcOp: begin
                dec_is_op = 1'b1;
                if (funct7 == Funct7Std) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu = AluAdd;
                        3'b001:  dec_alu = AluSll;
                        3'b010:  dec_alu = AluSlt;
                        3'b011:  dec_alu = AluSltu;
                        3'b100:  dec_alu = AluXor;
                        3'b101:  dec_alu = AluSrl;
                        3'b110:  dec_alu = AluOr;
                        default: dec_alu = AluAnd;
                    endcase
                end else if (funct7 == Funct7Alt) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_alu   = AluSub;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_alu   = AluSra;
                    end
                end
            end
            default: ;
        endcase
    end

    // Register read with same-cycle writeback bypass
    logic                 wb_hit_rs1, wb_hit_rs2;
    logic [CPU_WIDTH-1:0] rs1_val, rs2_val;
    logic [CPU_WIDTH-1:0] imm_i, shamt;
    logic [CPU_WIDTH-1:0] op_b_dec;

    assign wb_hit_rs1 = bus.wb_valid && (bus.wb_rd == rs1);
    assign wb_hit_rs2 = bus.wb_valid && (bus.wb_rd == rs2);

    always_comb begin
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_hit_rs1) begin
            rs1_val = bus.wb_data;
        end else begin
            rs1_val = rf_q[rs1];
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_hit_rs2) begin
            rs2_val = bus.wb_data;
        end else begin
            rs2_val = rf_q[rs2];
        end
    end

    assign imm_i = {{(CPU_WIDTH-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign shamt = {{(CPU_WIDTH-5){1'b0}}, bus.in_instr[24:20]};

    always_comb begin
        if (dec_is_op) begin
            op_b_dec = rs2_val;
        end else if (dec_shift) begin
            op_b_dec = shamt;
        end else begin
            op_b_dec = imm_i;
        end
    end

    // A pending destination retiring this very cycle no longer blocks its readers.
    logic rs1_busy, rs2_busy, hazard, in_ready, accept;

    assign rs1_busy = busy_q[rs1] && !wb_hit_rs1;
    assign rs2_busy = busy_q[rs2] && !wb_hit_rs2;
    assign hazard   = dec_legal && (rs1_busy || (dec_is_op && rs2_busy));
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (dec_legal) begin
                op_a_d    = rs1_val;
                op_b_d    = op_b_dec;
                alu_op_d  = dec_alu;
                rd_d      = dec_rd;
                illegal_d = 1'b0;
            end else begin
                op_a_d    = '0;
                op_b_d    = '0;
                alu_op_d  = AluAdd;
                rd_d      = 5'd0;
                illegal_d = 1'b1;
            end
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // Set is applied after clear so a same-index issue wins over a retiring writeback.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            rf_d[bus.wb_rd]   = bus.wb_data;
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (accept && dec_legal && (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_op_q    <= AluAdd;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            rf_q        <= rf_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op_a    = op_a_q;
    assign bus.out_op_b    = op_b_q;
    assign bus.out_alu_op  = alu_op_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_kamacore_decode_issue.sv
// Randomized bench for kamacore_decode_issue: a register/busy reference model predicts
// each issued slot into a queue that an independent monitor drains on every consume.
module tb_kamacore_decode_issue;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    kamacore_decode_issue_if #(.CPU_WIDTH(32)) bus ();

    kamacore_decode_issue #(
        .CPU_WIDTH(32),
        .NUM_REGS (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] regs_m [32];
    bit          busy_m [32];
    int          checks = 0;
    int          passes = 0;

    // ALU code for funct3 under the standard (funct7 = 0) encoding
    localparam int BaseAlu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rd_val(input logic [4:0] r, input bit wv,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (wv && wr == r) return wd;
        return regs_m[r];
    endfunction

    function automatic bit is_busy(input logic [4:0] r, input bit wv, input logic [4:0] wr);
        return busy_m[r] && !(wv && wr == r);
    endfunction

    task automatic ref_decode(input logic [31:0] ins, output bit legal, output bit is_op,
                              output logic [3:0] alu);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        legal = 0;
        is_op = 0;
        alu = 4'd0;
        if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else legal = 1;
            alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : 4'(BaseAlu[f3]);
        end else if (ins[6:0] == 7'h33) begin
            is_op = 1;
            if (f7 == 7'h00) begin
                legal = 1;
                alu = 4'(BaseAlu[f3]);
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                legal = 1;
                alu = (f3 == 3'd0) ? 4'd1 : 4'd7;
            end
        end
        if (!legal) alu = 4'd0;
    endtask

    // One clock of stimulus: drive after the edge, predict at the falling edge, commit at the edge.
    task automatic cycle(input bit rst, input bit iv, input logic [31:0] ins, input bit ordy,
                         input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                         output bit acc);
        bit          legal, is_op, hz, rdy;
        logic [3:0]  alu;
        logic [2:0]  f3;
        exp_t        e;
        rst_n         = rst;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        @(negedge clk);
        ref_decode(ins, legal, is_op, alu);
        f3  = ins[14:12];
        hz  = legal && (is_busy(ins[19:15], wv, wr) || (is_op && is_busy(ins[24:20], wv, wr)));
        rdy = rst && (exp_q.size() == 0 || ordy) && !hz;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        acc = iv && rdy;
        e = '0;
        if (legal) begin
            e.a = rd_val(ins[19:15], wv, wr, wd);
            if (is_op) e.b = rd_val(ins[24:20], wv, wr, wd);
            else if (f3 == 3'd1 || f3 == 3'd5) e.b = {27'd0, ins[24:20]};
            else e.b = {{20{ins[31]}}, ins[31:20]};
            e.alu = alu;
            e.rd  = ins[11:7];
        end else begin
            e.ill = 1'b1;
        end
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            for (int r = 0; r < 32; r++) begin
                regs_m[r] = 32'd0;
                busy_m[r] = 0;
            end
        end else begin
            if (acc) exp_q.push_back(e);
            if (wv && wr != 5'd0) begin
                regs_m[wr] = wd;
                busy_m[wr] = 0;
            end
            if (acc && legal && ins[11:7] != 5'd0) busy_m[ins[11:7]] = 1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL slot: issued rd=%0d with nothing expected", bus.out_rd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("op_a", bus.out_op_a, mon_e.a);
                chk("op_b", bus.out_op_b, mon_e.b);
                chk("alu_op", 32'(bus.out_alu_op), 32'(mon_e.alu));
                chk("rd", 32'(bus.out_rd), 32'(mon_e.rd));
                chk("illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
            end
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int k;
        k   = int'($urandom_range(0, 7));
        f7  = (k < 5) ? 7'h00 : (k < 7) ? 7'h20 : 7'($urandom);
        f3  = 3'($urandom);
        k   = int'($urandom_range(0, 9));
        opc = (k < 5) ? 7'h13 : (k < 9) ? 7'h33 : 7'($urandom);
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                5'($urandom_range(0, 7)), opc};
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc, have, raised, rst, iv, ordy, wv;
        logic [31:0] instr, wd;
        logic [4:0]  wr;
        int          wait_cnt;
        int          bl[$];
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0;
        bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
        @(posedge clk); #1;

        cycle(0, 1, 32'hFFB00093, 1, 0, 5'd0, 0, acc);
        cycle(0, 1, 32'hFFB00093, 1, 0, 5'd0, 0, acc);
        chk("rst_op_a", bus.out_op_a, 0);
        chk("rst_op_b", bus.out_op_b, 0);
        chk("rst_alu_op", 32'(bus.out_alu_op), 0);
        chk("rst_rd", 32'(bus.out_rd), 0);
        chk("rst_illegal", 32'(bus.out_illegal), 0);

        cycle(1, 1, 32'hFFB00093, 1, 0, 5'd0, 0, acc);      // ADDI x1,x0,-5
        cycle(1, 1, 32'h002081B3, 1, 0, 5'd0, 0, acc);      // ADD x3,x1,x2 stalls
        cycle(1, 1, 32'h002081B3, 1, 1, 5'd1, 32'd7, acc);  // bypassed writeback frees it
        cycle(1, 1, 32'h41F2D213, 1, 1, 5'd3, 32'h11, acc); // SRAI x4,x5,31
        cycle(1, 1, 32'h03F2D213, 1, 1, 5'd4, 32'h22, acc); // bad funct7 -> illegal
        cycle(1, 1, 32'hFFF03313, 1, 0, 5'd0, 0, acc);      // SLTIU x6,x0,-1
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h00100393, 0, 0, 5'd0, 0, acc);
        cycle(1, 1, 32'h00100393, 1, 0, 5'd0, 0, acc);
        cycle(1, 1, 32'h00200113, 1, 0, 5'd0, 0, acc);
        cycle(1, 1, 32'h00500293, 1, 0, 5'd0, 0, acc);
        cycle(1, 0, 32'h0, 1, 0, 5'd0, 0, acc);

        cycle(1, 1, 32'h00100093, 1, 0, 5'd0, 0, acc);      // ADDI x1,x0,1
        cycle(1, 1, 32'h002081B3, 0, 0, 5'd0, 0, acc);
        cycle(0, 1, 32'h002081B3, 0, 0, 5'd0, 0, acc);      // reset mid-stall
        cycle(1, 1, 32'h002081B3, 1, 0, 5'd0, 0, acc);      // x1 reads 0, no stall
        cycle(1, 0, 32'h0, 1, 0, 5'd0, 0, acc);

        have = 0; raised = 0; wait_cnt = 0; instr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                instr = gen_instr();
                have = 1; raised = 0; wait_cnt = 0;
            end
            if (!raised) raised = ($urandom_range(0, 3) != 0);
            iv   = raised;
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 499) != 0);
            bl.delete();
            for (int r = 1; r < 32; r++) if (busy_m[r]) bl.push_back(r);
            wd = $urandom;
            if (bl.size() != 0 && $urandom_range(0, 1) == 1) begin
                wv = 1;
                wr = 5'(bl[$urandom_range(0, bl.size() - 1)]);
            end else begin
                wv = ($urandom_range(0, 3) == 0);
                wr = 5'($urandom_range(0, 7));
            end
            cycle(rst, iv, instr, ordy, wv, wr, wd, acc);
            if (acc) begin
                have = 0;
            end else if (++wait_cnt > 60) begin
                checks++;
                $display("FAIL stall_bound: %h not accepted in 60 cycles", instr);
                have = 0;
            end
        end
        cycle(1, 0, 32'h0, 1, 0, 5'd0, 0, acc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
